// File: rtl/ins_prefetch_buffer.sv
// Instruction window buffer: serves DEPTH aligned words around the fetch PC and
// refills the whole window from memory, one outstanding read at a time, on a miss.
module ins_prefetch_buffer #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 16,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_req,
  input  logic            flush,
  output logic [XLEN-1:0] ins_out,
  output logic            ins_valid,
  output logic            stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int              CW       = $clog2(DEPTH);
  localparam logic [XLEN-1:0] WIN_MASK = XLEN'(DEPTH * 4 - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_FILL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_base;
  logic [XLEN-1:0] r_ins_out;
  logic [XLEN-1:0] r_mem_addr;
  logic [CW-1:0]   r_cnt;
  logic            r_ins_valid;
  logic            r_mem_req;
  logic            r_pend;
  logic [XLEN-1:0] r_words [DEPTH];

  logic [XLEN-1:0] w_off;
  logic            w_aligned;
  logic            w_in_win;
  logic            w_serve;
  logic            w_hit;
  logic            w_mis;
  logic            w_miss;
  logic            w_accept;
  logic            w_resp;
  logic            w_last;
  logic            w_drain;
  logic            w_stall;

  // A PC below base wraps to a huge offset and therefore decodes as a miss.
  assign w_off     = (pc_in - r_base) >> 2;
  assign w_aligned = (pc_in[1:0] == 2'b00);
  assign w_in_win  = (w_off < XLEN'(DEPTH));
  assign w_serve   = !flush && pc_req && ((r_state == S_EMPTY) || (r_state == S_READY));
  assign w_hit     = w_serve && w_aligned && (r_state == S_READY) && w_in_win;
  assign w_mis     = w_serve && !w_aligned;
  assign w_miss    = w_serve && w_aligned && !w_hit;
  assign w_accept  = r_mem_req && mem_ready;
  assign w_resp    = r_pend && mem_rvalid;
  assign w_last    = w_resp && (r_state == S_FILL) && (r_cnt == CW'(DEPTH - 1));
  // A response is still owed after this edge if one is pending or being accepted now.
  assign w_drain   = (r_pend && !mem_rvalid) || w_accept;

  // Next-state and stall decode; flush overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_EMPTY, S_READY: begin
        if (w_miss) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = r_state;
        end
        w_stall = w_miss;
      end
      S_FILL: begin
        if (w_last) begin
          w_state_nxt = S_READY;
        end else begin
          w_state_nxt = S_FILL;
        end
        w_stall = 1'b1;
      end
      S_DRAIN: begin
        if (w_resp) begin
          w_state_nxt = S_EMPTY;
        end else begin
          w_state_nxt = S_DRAIN;
        end
        w_stall = 1'b1;
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_stall     = 1'b0;
      end
    endcase
    if (flush) begin
      w_state_nxt = w_drain ? S_DRAIN : S_EMPTY;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, output and memory-handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_base      <= '0;
      r_cnt       <= '0;
      r_ins_out   <= '0;
      r_ins_valid <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ins_valid <= w_hit || w_mis;
      if (w_hit) begin
        r_ins_out <= r_words[w_off[CW-1:0]];
      end else if (w_mis) begin
        r_ins_out <= NOP;
      end
      if (flush) begin
        r_mem_req <= 1'b0;
        r_pend    <= w_drain;
      end else if (w_miss) begin
        r_base     <= pc_in & ~WIN_MASK;
        r_cnt      <= '0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= pc_in & ~WIN_MASK;
      end else if (w_accept) begin
        r_mem_req <= 1'b0;
        r_pend    <= 1'b1;
      end else if (w_resp) begin
        r_pend <= 1'b0;
        if (r_state == S_FILL) begin
          r_cnt <= r_cnt + CW'(1);
          if (!w_last) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_mem_addr + XLEN'(4);
          end
        end
      end
    end
  end

  // Window storage; contents are meaningless until a fill completes.
  always_ff @(posedge clk) begin
    if (w_resp && (r_state == S_FILL)) begin
      r_words[r_cnt] <= mem_rdata;
    end
  end

  assign ins_out   = r_ins_out;
  assign ins_valid = r_ins_valid;
  assign stall     = w_stall;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_ins_prefetch_buffer.sv
// Self-checking bench for ins_prefetch_buffer: directed scenarios plus random
// fetches against a window-level reference model and a memory responder.
module tb_ins_prefetch_buffer;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk, rst, pc_req, flush, mem_ready, mem_rvalid;
  logic [31:0] pc_in, mem_rdata, ins_out, mem_addr;
  logic        ins_valid, stall, mem_req;

  int checks = 0;
  int errors = 0;

  // Memory responder knobs and observations.
  logic [31:0] key        = 32'hA5A5_0000;
  int          lat        = 1;
  int          ready_hold = 0;
  bit          spur       = 1'b0;
  int          n_acc      = 0;
  int          n_rv       = 0;
  logic [31:0] acc_q[$];

  // Reference model: which aligned 64-byte window is buffered and with which data key.
  bit          m_valid = 1'b0;
  logic [31:0] m_base  = 32'd0;
  logic [31:0] m_key   = 32'd0;

  ins_prefetch_buffer #(.XLEN(32), .DEPTH(16), .NOP(NOPW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_req(pc_req), .flush(flush),
    .ins_out(ins_out), .ins_valid(ins_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Memory: accepts on mem_req&&mem_ready, answers key^addr after a latency.
  initial begin : responder
    bit          acc_flag, pend, held;
    int          wait_left;
    logic [31:0] acc_addr, held_addr, rq;
    acc_flag = 1'b0; pend = 1'b0; held = 1'b0; wait_left = 0;
    acc_addr = '0; held_addr = '0; rq = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (acc_flag) begin
        n_acc++;
        acc_q.push_back(acc_addr);
        pend      = 1'b1;
        wait_left = (lat == 0) ? int'($urandom_range(4, 1)) : lat;
        rq        = key ^ acc_addr;
      end
      mem_rvalid = 1'b0;
      if (pend) begin
        wait_left--;
        if (wait_left <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rq;
          pend       = 1'b0;
          n_rv++;
        end
      end else if (spur) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        spur       = 1'b0;
      end
      if (mem_req === 1'b1) chk({31'd0, pend}, 32'd0, "single_outstanding");
      if (held) begin
        chk({31'd0, mem_req}, 32'd1, "req_hold");
        chk(mem_addr, held_addr, "addr_hold");
      end
      if (mem_req === 1'b1 && ready_hold > 0) begin
        held = 1'b1; held_addr = mem_addr; mem_ready = 1'b0; ready_hold--;
      end else begin
        held = 1'b0; mem_ready = 1'b1;
      end
      acc_flag = (mem_req === 1'b1) && mem_ready;
      acc_addr = mem_addr;
    end
  end

  // One fetch from idle: predicts hit/miss/misaligned from the model, waits to be served.
  task automatic fetch(input logic [31:0] pc, input string tag);
    bit          fill, served;
    int          cyc, start;
    logic [31:0] exp;
    fill = 1'b0;
    if (pc[1:0] != 2'b00) begin
      exp = NOPW;
    end else begin
      if (!(m_valid && pc >= m_base && (pc - m_base) < 32'd64)) begin
        fill = 1'b1; m_valid = 1'b1; m_base = pc & ~32'h3F; m_key = key;
      end
      exp = m_key ^ pc;
    end
    start = acc_q.size();
    pc_in = pc; pc_req = 1'b1; served = 1'b0; cyc = 0;
    @(negedge clk);
    chk({31'd0, stall}, {31'd0, fill}, {tag, "_stall"});
    while (!served && cyc < 400) begin
      if (stall === 1'b0) served = 1'b1;
      @(posedge clk); #1; cyc++;
      if (!served) @(negedge clk);
    end
    pc_req = 1'b0;
    chk({31'd0, served}, 32'd1, {tag, "_served"});
    chk({31'd0, ins_valid}, 32'd1, {tag, "_valid"});
    chk(ins_out, exp, {tag, "_ins"});
    chk(acc_q.size() - start, fill ? 32'd16 : 32'd0, {tag, "_nreq"});
    if (fill) begin
      for (int k = 0; k < 16 && start + k < acc_q.size(); k++)
        chk(acc_q[start + k], m_base + 32'(4 * k), {tag, "_addr"});
    end
    @(posedge clk); #1;
    chk({31'd0, ins_valid}, 32'd0, {tag, "_idle"});
    chk(ins_out, exp, {tag, "_hold"});
  endtask

  initial begin : main
    int          s, r, cyc, sel;
    logic [31:0] pc;
    rst = 1'b1; pc_req = 1'b0; pc_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(ins_out, 32'd0, "rst_ins");
    chk({31'd0, ins_valid}, 32'd0, "rst_valid");
    chk({31'd0, stall}, 32'd0, "rst_stall");
    chk({31'd0, mem_req}, 32'd0, "rst_req");
    chk(mem_addr, 32'd0, "rst_addr");
    rst = 1'b0;

    fetch(32'h100, "fill100");
    // Back-to-back hits, one per cycle, no memory traffic.
    pc_in = 32'h104; pc_req = 1'b1;
    @(posedge clk); #1;
    chk({31'd0, ins_valid}, 32'd1, "b2b0_valid"); chk(ins_out, 32'hA5A5_0104, "b2b0_ins");
    pc_in = 32'h108;
    @(posedge clk); #1;
    chk({31'd0, ins_valid}, 32'd1, "b2b1_valid"); chk(ins_out, 32'hA5A5_0108, "b2b1_ins");
    chk({31'd0, mem_req}, 32'd0, "b2b_noreq");
    pc_in = 32'h13C;
    @(posedge clk); #1;
    chk({31'd0, ins_valid}, 32'd1, "b2b2_valid"); chk(ins_out, 32'hA5A5_013C, "b2b2_ins");
    pc_req = 1'b0;
    @(posedge clk); #1;
    chk({31'd0, ins_valid}, 32'd0, "b2b_end");

    ready_hold = 4;
    fetch(32'h140, "fill140");
    fetch(32'h0FC, "below_base");
    fetch(32'h102, "misaligned");
    fetch(32'hFFFF_FFFC, "top");
    fetch(32'hFFFF_FFC0, "top_hit");
    spur = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    fetch(32'hFFFF_FFE0, "after_spur");

    // Flush with the sixth request accepted and its response three cycles out.
    lat = 3; s = n_acc; r = n_rv; cyc = 0;
    pc_in = 32'h300; pc_req = 1'b1;
    while (n_acc - s < 6 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk(n_acc - s, 32'd6, "flush_acc6");
    chk(n_rv - r, 32'd5, "flush_words5");
    flush = 1'b1; pc_req = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk({31'd0, stall}, 32'd1, "drain_stall");
    chk({31'd0, mem_req}, 32'd0, "drain_req");
    chk({31'd0, ins_valid}, 32'd0, "drain_valid");
    @(posedge clk); #1;
    chk({31'd0, stall}, 32'd0, "drain_done");
    m_valid = 1'b0; lat = 1;
    fetch(32'h100, "refill100");

    // Flush with nothing outstanding invalidates the window.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk({31'd0, stall}, 32'd0, "flush_stall");
    chk({31'd0, ins_valid}, 32'd0, "flush_valid");
    m_valid = 1'b0;
    fetch(32'h104, "after_flush");

    // Reset mid-fill with a response still in flight.
    lat = 4; s = n_acc; cyc = 0;
    pc_in = 32'h200; pc_req = 1'b1;
    while (n_acc - s < 3 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1; pc_req = 1'b0; r = n_rv;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(ins_out, 32'd0, "mid_rst_ins");
    chk({31'd0, ins_valid}, 32'd0, "mid_rst_valid");
    chk({31'd0, stall}, 32'd0, "mid_rst_stall");
    chk({31'd0, mem_req}, 32'd0, "mid_rst_req");
    chk(mem_addr, 32'd0, "mid_rst_addr");
    repeat (6) begin @(posedge clk); #1; end
    chk(n_rv - r, 32'd1, "late_rvalid_sent");
    chk({31'd0, mem_req}, 32'd0, "late_rvalid_req");
    chk({31'd0, stall}, 32'd0, "late_rvalid_stall");
    m_valid = 1'b0; m_base = 32'd0;
    fetch(32'h0, "post_reset");

    // Random fetches against the window model.
    for (int i = 0; i < 30; i++) begin
      key = $urandom; lat = 0; ready_hold = int'($urandom_range(2, 0));
      sel = int'($urandom_range(9, 0));
      if (sel <= 4 && m_valid)  pc = m_base + 32'(4 * $urandom_range(15, 0));
      else if (sel == 7)        pc = ($urandom & 32'hFFC) | 32'($urandom_range(3, 1));
      else if (sel == 8)        pc = m_base - 32'd4;
      else                      pc = $urandom & 32'hFFC;
      if (sel == 9) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        m_valid = 1'b0;
      end
      fetch(pc, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_prefetch_buffer.md
Name: ins_prefetch_buffer

Overview:
Parametrised instruction window buffer that sits between the fetch-stage PC and instruction memory. It holds DEPTH consecutive instruction words starting at a window base aligned to DEPTH*4 bytes. A hit returns the instruction one cycle later. A miss stalls fetch and refills the whole window from memory through a single-outstanding request/response handshake. Flush support covers branch redirects.

Parameters:
XLEN, 32, instruction, address and data width in bits.
DEPTH, 16, words per window; a power of two, minimum 2.
NOP, 32'h00000013, word driven on misaligned fetch.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
pc_in  in  XLEN  fetch byte address.
pc_req  in  1  fetch request; pc_in is valid this cycle.
flush  in  1  invalidates the window and aborts any fill.
ins_out  out  XLEN  registered instruction.
ins_valid  out  1  ins_out holds a new instruction this cycle; one-cycle pulse per served request.
stall  out  1  buffer cannot serve; upstream holds pc_in and pc_req.
mem_req  out  1  memory read request.
mem_addr  out  XLEN  word-aligned read address.
mem_ready  in  1  memory accepts the request when mem_req=1 and mem_ready=1.
mem_rvalid  in  1  read data returned.
mem_rdata  in  XLEN  read data.

Behaviour:
- Reset, whenever rst=1 including mid-fill:
  - ins_out=0, ins_valid=0, stall=0, mem_req=0, mem_addr=0.
  - base=0, fill counter=0, state EMPTY, window invalid.
  - A response already in flight is ignored after reset.
- States and transitions:
  - EMPTY: window invalid.
  - READY: window valid.
  - FILL: refilling.
  - DRAIN: waiting to discard one in-flight response.
- Offset: off = (pc_in - base) >> 2, using XLEN-bit unsigned subtraction. If pc_in < base, off wraps large and the access is a miss.
- Hit: state READY, pc_req=1, pc_in[1:0]==0, off < DEPTH.
  - Next cycle: ins_out = word[off], ins_valid=1.
  - stall=0 throughout.
  - Back-to-back hits sustain one per cycle.
- Misaligned: pc_req=1 and pc_in[1:0]!=0, in any state other than FILL/DRAIN.
  - Next cycle: ins_out=NOP, ins_valid=1.
  - No refill.
- Miss: pc_req=1, aligned, and either state EMPTY or off >= DEPTH.
  - Same cycle: stall=1 (combinational from the miss decode).
  - Next cycle: base = pc_in & ~(DEPTH*4-1), counter=0, state FILL, window invalid.
- FILL:
  - stall=1; ins_valid=0; ins_out holds its previous value.
  - Request k: mem_req=1, mem_addr = base + 4*k. Hold both stable until mem_ready=1.
  - After acceptance, mem_req=0 until mem_rvalid=1. At most one request outstanding.
  - On mem_rvalid: word[k] = mem_rdata, k increments, next request issued the following cycle.
  - After word DEPTH-1 is written: state READY, stall=0. The held pc is then evaluated as a normal hit in that READY cycle.
- Window wrap: base is DEPTH*4-aligned, so base+4*(DEPTH-1) never wraps past 2^XLEN.
- flush, dominates pc_req and misses:
  - Next cycle: ins_valid=0, stall=0, window invalid.
  - If a request was accepted and its response is pending: state DRAIN, mem_req=0, stall=1 until mem_rvalid arrives. That response is discarded, then state EMPTY.
  - Otherwise: state EMPTY, and any unaccepted mem_req drops.
  - flush while already in DRAIN stays in DRAIN.
- mem_rvalid with no outstanding request is ignored.
- pc_req=0: ins_valid=0 next cycle, ins_out holds.

Test Plan:
- Reset, then pc_req=1, pc_in=0x100 -> stall=1; mem_addr sequence 0x100,0x104,...,0x13C (16 requests, mem_ready=1, mem_rvalid one cycle after accept, rdata=addr^0xA5A5_0000); then stall=0, ins_out=0xA5A5_0100 with ins_valid=1.
- After fill, pc 0x104,0x108,0x13C on consecutive cycles -> ins_out 0xA5A5_0104, 0xA5A5_0108, 0xA5A5_013C, with ins_valid=1 on three consecutive cycles and no mem_req.
- pc_in=0x140 -> miss, refill from 0x140..0x17C. Then pc_in=0x0FC, which is below base -> miss, base=0xC0.
- pc_in=0x102 while READY -> ins_out=0x00000013, ins_valid=1, no refill.
- Flush after 5 words with request 6 accepted, mem_rvalid 3 cycles later -> state DRAIN, stall=1, data discarded. Then pc_in=0x100 refills all 16 words starting at 0x100.
- mem_ready held low 4 cycles -> mem_req/mem_addr stable. rst=1 mid-fill -> all outputs zero next cycle; a late mem_rvalid is ignored and the window stays invalid.
